mipi_hs_byte_aligner: RTL and testbench



---
 rtl/mipi_rx_pkg.sv | 25 ++
 rtl/mipi_hs_byte_aligner_if.sv | 31 +++
 rtl/mipi_sync_detect.sv | 40 ++++
 rtl/mipi_hs_byte_aligner.sv | 127 ++++++++++++
 tb/tb_mipi_hs_byte_aligner.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/mipi_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mipi_rx_pkg
// Brief   : Shared MIPI D-PHY RX types and constants for the lane blocks.
// Revision: 1.0  initial release
// ============================================================================
package mipi_rx_pkg;

    localparam int unsigned LANE_W         = 8;
    localparam logic [7:0]  MIPI_SYNC_BYTE = 8'hB8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HUNT    = 2'd1,
        LOCKED  = 2'd2,
        WAIT_LP = 2'd3
    } rx_state_e;

    // Byte starting at bit k of the {current, previous} window.
    function automatic logic [7:0] win_slice(input logic [15:0] w, input logic [2:0] k);
        return w[k +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mipi_hs_byte_aligner_if.sv
`default_nettype none
// ============================================================================
// Module  : mipi_hs_byte_aligner_if
// Brief   : Lane-side inputs and aligned-byte outputs of one HS byte aligner.
// Revision: 1.0  initial release
// ============================================================================
interface mipi_hs_byte_aligner_if;
    import mipi_rx_pkg::*;

    logic              BIT_ALGN_DONE;
    logic              LP_IN;
    logic [LANE_W-1:0] RX_DATA;
    logic [LANE_W-1:0] BYTE_DATA;
    logic              BYTE_VALID;
    logic              SOT;
    logic              ALIGNED;
    logic [2:0]        OFFSET;
    logic              SYNC_ERR;

    modport master (
        output BIT_ALGN_DONE, LP_IN, RX_DATA,
        input  BYTE_DATA, BYTE_VALID, SOT, ALIGNED, OFFSET, SYNC_ERR
    );

    modport slave (
        input  BIT_ALGN_DONE, LP_IN, RX_DATA,
        output BYTE_DATA, BYTE_VALID, SOT, ALIGNED, OFFSET, SYNC_ERR
    );

endinterface
`default_nettype wire

// File: rtl/mipi_sync_detect.sv
`default_nettype none
// ============================================================================
// Module  : mipi_sync_detect
// Brief   : Finds the sync byte at any of 8 offsets in a 16-bit window;
//           the lowest matching offset wins.
// Revision: 1.0  initial release
// ============================================================================
module mipi_sync_detect
    import mipi_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = MIPI_SYNC_BYTE
) (
    input  wire logic [15:0] i_window,
    output logic             o_hit,
    output logic [2:0]       o_k
);

    logic [7:0] w_match;
    logic       w_unused_msb;

    // The top bit only belongs to an offset-8 candidate, which is the next
    // cycle's offset 0.
    assign w_unused_msb = i_window[15];

    for (genvar g = 0; g < 8; g++) begin : g_cand
        assign w_match[g] = (i_window[g +: 8] == SYNC_BYTE);
    end

    always_comb begin
        o_hit = |w_match;
        o_k   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_match[i]) begin
                o_k = 3'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mipi_hs_byte_aligner.sv
`default_nettype none
// ============================================================================
// Module  : mipi_hs_byte_aligner
// Brief   : Hunts the HS sync byte across two deserialized bytes, locks the
//           bit offset and streams byte-aligned payload until LP mode.
// Revision: 1.0  initial release
// ============================================================================
module mipi_hs_byte_aligner
    import mipi_rx_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE    = MIPI_SYNC_BYTE,
    parameter int unsigned HUNT_TIMEOUT = 32,
    parameter int unsigned TO_W         = $clog2(HUNT_TIMEOUT + 1)
) (
    input  wire logic         SCLK,
    input  wire logic         RESET,
    mipi_hs_byte_aligner_if.slave lane
);

    rx_state_e         state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [LANE_W-1:0] prev_q;
    logic [LANE_W-1:0] byte_data_q, byte_data_d;
    logic              byte_valid_q, byte_valid_d;
    logic              sot_q, sot_d;
    logic              aligned_q, aligned_d;
    logic [2:0]        offset_q, offset_d;
    logic              sync_err_q, sync_err_d;

    logic [15:0]       w_window;
    logic              w_hit;
    logic [2:0]        w_k;
    logic              w_link_up;

    assign w_window  = {lane.RX_DATA, prev_q};
    assign w_link_up = lane.BIT_ALGN_DONE && !lane.LP_IN;

    mipi_sync_detect #(
        .SYNC_BYTE (SYNC_BYTE)
    ) u_sync_detect (
        .i_window (w_window),
        .o_hit    (w_hit),
        .o_k      (w_k)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        sot_d        = 1'b0;
        offset_d     = offset_q;
        sync_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (w_link_up) begin
                    state_d = HUNT;
                end
            end
            HUNT: begin
                cnt_d = cnt_q + 1'b1;
                // Losing the link outranks a match, and a match outranks timeout.
                if (!w_link_up) begin
                    state_d = IDLE;
                end else if (w_hit) begin
                    state_d  = LOCKED;
                    offset_d = w_k;
                    sot_d    = 1'b1;
                end else if (cnt_q == TO_W'(HUNT_TIMEOUT - 1)) begin
                    state_d    = WAIT_LP;
                    sync_err_d = 1'b1;
                end
            end
            LOCKED: begin
                if (!w_link_up) begin
                    state_d = IDLE;
                end else begin
                    byte_data_d  = win_slice(w_window, offset_q);
                    byte_valid_d = 1'b1;
                end
            end
            WAIT_LP: begin
                if (lane.LP_IN || !lane.BIT_ALGN_DONE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        aligned_d = (state_d == LOCKED);
    end

    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            prev_q       <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            sot_q        <= 1'b0;
            aligned_q    <= 1'b0;
            offset_q     <= 3'd0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prev_q       <= lane.RX_DATA;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            sot_q        <= sot_d;
            aligned_q    <= aligned_d;
            offset_q     <= offset_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign lane.BYTE_DATA  = byte_data_q;
    assign lane.BYTE_VALID = byte_valid_q;
    assign lane.SOT        = sot_q;
    assign lane.ALIGNED    = aligned_q;
    assign lane.OFFSET     = offset_q;
    assign lane.SYNC_ERR   = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mipi_hs_byte_aligner.sv
`default_nettype none
// ============================================================================
// Module  : tb_mipi_hs_byte_aligner
// Brief   : Directed bench; payload expectations come from a bench-built bit
//           stream and are checked through a scoreboard queue.
// Revision: 1.0  initial release
// ============================================================================
module tb_mipi_hs_byte_aligner;
    import mipi_rx_pkg::*;

    logic SCLK = 1'b0;
    logic RESET;

    mipi_hs_byte_aligner_if lane ();

    mipi_hs_byte_aligner #(
        .SYNC_BYTE    (8'hB8),
        .HUNT_TIMEOUT (32)
    ) dut (
        .SCLK  (SCLK),
        .RESET (RESET),
        .lane  (lane)
    );

    always #5 SCLK = ~SCLK;

    int         n_pass  = 0;
    int         n_total = 0;
    int         sot_seen = 0;
    int         err_seen = 0;
    int         sot_exp  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_bytes [0:31];
    logic [7:0] pay      [0:31];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // One clock edge, then inspect outputs 1 time unit later.
    task automatic tick();
        @(posedge SCLK);
        #1;
        if (lane.SOT === 1'b1)      sot_seen++;
        if (lane.SYNC_ERR === 1'b1) err_seen++;
        if (lane.BYTE_VALID !== 1'b0) begin
            if (exp_q.size() == 0) chk("unexpected_valid", 32'(lane.BYTE_VALID), 32'h0);
            else                   chk("payload", 32'(lane.BYTE_DATA), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic drive(input logic lp, input logic bad, input logic [7:0] d);
        lane.LP_IN         = lp;
        lane.BIT_ALGN_DONE = bad;
        lane.RX_DATA       = d;
        tick();
    endtask

    // Serial stream: one zero byte, k zero bits, sync byte, pay[0..np-1],
    // zero tail; cut into np+4 deserialized bytes (LSB = earliest bit).
    task automatic build(input int k, input int np);
        logic [255:0] bits;
        bits    = '0;
        pay[np] = 8'h00;
        bits[8 + k +: 8] = 8'hB8;
        for (int j = 0; j < np; j++) bits[16 + k + 8 * j +: 8] = pay[j];
        for (int i = 0; i < np + 4; i++) rx_bytes[i] = bits[8 * i +: 8];
    endtask

    // Enter HUNT, present the sync, check SOT, then stream bytes 3..last.
    task automatic lock_burst(input int k, input int last);
        drive(1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b1, rx_bytes[0]);
        drive(1'b0, 1'b1, rx_bytes[1]);
        chk("no_early_sot", 32'(lane.SOT), 32'h0);
        drive(1'b0, 1'b1, rx_bytes[2]);
        sot_exp++;
        chk("sot",          32'(lane.SOT),        32'h1);
        chk("aligned",      32'(lane.ALIGNED),    32'h1);
        chk("offset",       32'(lane.OFFSET),     32'(k));
        chk("valid_at_sot", 32'(lane.BYTE_VALID), 32'h0);
        for (int i = 3; i <= last; i++) begin
            exp_q.push_back(pay[i - 3]);
            drive(1'b0, 1'b1, rx_bytes[i]);
            if (i == 3) chk("sot_one_cycle", 32'(lane.SOT), 32'h0);
        end
    endtask

    initial begin
        RESET              = 1'b1;
        lane.LP_IN         = 1'b1;
        lane.BIT_ALGN_DONE = 1'b0;
        lane.RX_DATA       = 8'h00;
        #12;
        chk("rst_byte_data", 32'(lane.BYTE_DATA),  32'h0);
        chk("rst_valid",     32'(lane.BYTE_VALID), 32'h0);
        chk("rst_sot",       32'(lane.SOT),        32'h0);
        chk("rst_aligned",   32'(lane.ALIGNED),    32'h0);
        chk("rst_offset",    32'(lane.OFFSET),     32'h0);
        chk("rst_sync_err",  32'(lane.SYNC_ERR),   32'h0);
        #2 RESET = 1'b0;
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'h00);

        // Offset 0: 0x00, 0xB8, 0x11, 0x22
        pay[0] = 8'h11;
        pay[1] = 8'h22;
        build(0, 2);
        lock_burst(0, 5);
        chk("queue_drained_k0", 32'(exp_q.size()), 32'h0);
        drive(1'b1, 1'b1, 8'h00);
        chk("eop_valid_k0",   32'(lane.BYTE_VALID), 32'h0);
        chk("eop_aligned_k0", 32'(lane.ALIGNED),    32'h0);
        drive(1'b1, 1'b1, 8'h00);

        // Offset 3 with 16 random payload bytes
        for (int j = 0; j < 16; j++) pay[j] = 8'($urandom);
        build(3, 16);
        lock_burst(3, 19);
        chk("queue_drained_k3", 32'(exp_q.size()), 32'h0);
        drive(1'b1, 1'b1, 8'h00);
        chk("eop_valid_k3", 32'(lane.BYTE_VALID), 32'h0);
        chk("offset_hold",  32'(lane.OFFSET),     32'h3);
        drive(1'b1, 1'b1, 8'h00);

        // Next burst at offset 5
        for (int j = 0; j < 4; j++) pay[j] = 8'($urandom);
        build(5, 4);
        lock_burst(5, 7);
        chk("queue_drained_k5", 32'(exp_q.size()), 32'h0);
        drive(1'b1, 1'b1, 8'h00);
        chk("eop_aligned_k5", 32'(lane.ALIGNED), 32'h0);
        drive(1'b1, 1'b1, 8'h00);

        // Hunt timeout: constant zero data in HS
        err_seen = 0;
        for (int d = 0; d < 40; d++) begin
            drive(1'b0, 1'b1, 8'h00);
            chk("sync_err_timing", 32'(lane.SYNC_ERR), (d == 32) ? 32'h1 : 32'h0);
        end
        chk("sync_err_count", 32'(err_seen), 32'h1);
        // Still waiting for LP: a sync pattern must be ignored
        drive(1'b0, 1'b1, 8'hB8);
        drive(1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b1, 8'h00);
        chk("wait_lp_no_lock", 32'(lane.ALIGNED), 32'h0);
        chk("wait_lp_no_sot",  32'(sot_seen),     32'(sot_exp));
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'h00);

        // BIT_ALGN_DONE drops while locked with sync bytes in the stream
        for (int j = 0; j < 6; j++) pay[j] = 8'hB8;
        build(2, 6);
        lock_burst(2, 5);
        err_seen = 0;
        drive(1'b0, 1'b0, rx_bytes[6]);
        chk("drop_valid",   32'(lane.BYTE_VALID), 32'h0);
        chk("drop_aligned", 32'(lane.ALIGNED),    32'h0);
        chk("drop_sot",     32'(lane.SOT),        32'h0);
        chk("drop_err",     32'(lane.SYNC_ERR),   32'h0);
        for (int i = 7; i < 10; i++) drive(1'b0, 1'b0, rx_bytes[i]);
        chk("drop_stays_idle", 32'(lane.ALIGNED),  32'h0);
        chk("drop_sot_count",  32'(sot_seen),      32'(sot_exp));
        chk("drop_err_count",  32'(err_seen),      32'h0);
        chk("queue_drained_drop", 32'(exp_q.size()), 32'h0);
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'h00);

        // Async reset between edges, mid-payload
        for (int j = 0; j < 8; j++) pay[j] = 8'($urandom);
        build(6, 8);
        lock_burst(6, 6);
        lane.RX_DATA = rx_bytes[7];
        #3 RESET = 1'b1;
        #1;
        chk("arst_byte_data", 32'(lane.BYTE_DATA),  32'h0);
        chk("arst_valid",     32'(lane.BYTE_VALID), 32'h0);
        chk("arst_aligned",   32'(lane.ALIGNED),    32'h0);
        chk("arst_offset",    32'(lane.OFFSET),     32'h0);
        chk("arst_sot",       32'(lane.SOT),        32'h0);
        chk("arst_sync_err",  32'(lane.SYNC_ERR),   32'h0);
        exp_q.delete();
        lane.LP_IN = 1'b1;
        @(negedge SCLK);
        @(negedge SCLK);
        RESET = 1'b0;
        drive(1'b1, 1'b1, 8'h00);
        chk("post_rst_quiet", 32'(lane.BYTE_VALID), 32'h0);
        drive(1'b1, 1'b1, 8'h00);

        for (int j = 0; j < 3; j++) pay[j] = 8'($urandom);
        build(1, 3);
        lock_burst(1, 6);
        chk("queue_drained_post_rst", 32'(exp_q.size()), 32'h0);
        drive(1'b1, 1'b1, 8'h00);
        chk("sot_total", 32'(sot_seen), 32'(sot_exp));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
